jtframe_mr_ddrld: RTL
=====================

// Module: jtframe_mr_ddrld
// PURPOSE
// Fast ROM loader on the DDR side of the MiSTer frame. The HPS places the ROM image in DDR;
// this block reads it back in Avalon bursts and serialises it into the byte-wide prog_* stream
// used by the SDRAM download path. Its ddrld_* outputs feed the DDR arbiter, which grants it
// the DDR port while downloading is high.
// PARAMETERS
// BURST     32        words (64-bit) per DDR burst, 1..128; also the local buffer depth
// DDR_BASE  29'h0     64-bit word address in DDR where the ROM image starts
// AW        27        prog_addr width (byte address)
// PORTS
// clk          in   1   system clock; DDR port runs on the same clock
// rst          in   1   synchronous, active-high reset
// start        in   1   1-cycle pulse: begin a load; sampled only in IDLE
// len          in   AW  ROM length in bytes; sampled together with start
// downloading  out  1   high from accepted start until the last byte is accepted
// done         out  1   1-cycle pulse after the last byte is accepted
// ddrld_burstcnt out 8  words requested in the current burst
// ddrld_addr   out  29  64-bit word address of the current burst
// ddrld_rd     out  1   read request, Avalon style
// ddrld_be     out  8   byte enables, constant 8'hFF
// ddr_busy     in   1   waitrequest from DDR/arbiter
// ddr_dout     in   64  read data
// ddr_dout_ready in 1   read data valid, one word per cycle
// prog_addr    out  AW  byte address of prog_data, starts at 0
// prog_data    out  8   byte to write
// prog_we      out  1   byte valid; held with addr/data stable until prog_rdy
// prog_rdy     in   1   downstream accepts the byte when prog_we & prog_rdy
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0 except ddrld_be=8'hFF. Reset mid-load aborts
//   immediately. There is no done pulse, and late ddr_dout_ready words are ignored.
// - Word count W = ceil(len/8). Remaining-words counter rw is loaded with W. Byte counter rb
//   is loaded with len.
// - FSM IDLE -> REQ -> RECV -> DRAIN -> (REQ | FIN) -> IDLE.
// - IDLE: on start with len==0, pulse done next cycle with no DDR access and no downloading.
//   On start with len!=0, set downloading, set ddrld_addr=DDR_BASE, go to REQ.
// - REQ: ddrld_rd=1, ddrld_burstcnt=min(BURST,rw). Both stay stable while ddr_busy=1.
//   The request is accepted in a cycle with ddrld_rd & !ddr_busy. ddrld_rd drops the next
//   cycle. Go to RECV.
// - RECV: each ddr_dout_ready writes ddr_dout into buffer[wcnt] and increments wcnt.
//   When wcnt==burstcnt, go to DRAIN, subtract burstcnt from rw, add burstcnt to ddrld_addr.
//   ddr_dout_ready in any other state is ignored.
// - DRAIN: bytes are emitted little-endian: byte k of a word is ddr_dout[8k+7:8k], k=0..7,
//   words in buffer order. prog_we stays high while bytes remain. Each accept increments
//   prog_addr and decrements rb.
// - Bytes past len are never emitted; the last word may be partially used.
// - When the burst buffer empties: rw!=0 -> REQ; rw==0 -> FIN.
// - A new REQ is issued no earlier than the cycle after the last accepted byte of the
//   previous burst. Bursts do not overlap.
// - FIN: downloading=0 and done=1 for exactly one cycle, then IDLE.
// - prog_addr wraps modulo 2^AW; len is limited to < 2^AW.
// - start outside IDLE is ignored. prog_rdy outside DRAIN is ignored.
// - Latency: first prog_we no earlier than 2 cycles after the first ddr_dout_ready.
// TESTING
// - len=16, BURST=32, no busy -> one burst: burstcnt=2, addr=DDR_BASE. Emits 16 bytes
//   at prog_addr 0..15 in little-endian order. done pulses once.
// - len=300, BURST=32 -> W=38. Two bursts: burstcnt 32 at DDR_BASE, then 6 at DDR_BASE+32.
//   Exactly 300 bytes; last byte is from word 37, byte 3.
// - ddr_busy high 5 cycles during REQ -> rd/addr/burstcnt stay stable; one request accepted.
// - prog_rdy toggling randomly -> each byte accepted exactly once; prog_data/addr stable
//   while stalled.
// - len=0 start -> done pulse, no ddrld_rd, downloading stays 0.
// - rst mid-RECV, then stray ddr_dout_ready -> back to IDLE, all outputs 0, no done.
//   A new start with len=8 loads correctly.

Source files
------------

// File: rtl/jtframe_mr_ddrld_if.sv
// DDR read port and byte-wide prog stream of the DDR ROM loader, bundled for the loader and its peers.
// master = loader side (issues DDR reads, drives prog bytes); slave = DDR arbiter / SDRAM download side.
interface jtframe_mr_ddrld_if #(
  parameter int AW = 27
);
  logic [7:0]    ddrld_burstcnt;
  logic [28:0]   ddrld_addr;
  logic          ddrld_rd;
  logic [7:0]    ddrld_be;
  logic          ddr_busy;
  logic [63:0]   ddr_dout;
  logic          ddr_dout_ready;
  logic [AW-1:0] prog_addr;
  logic [7:0]    prog_data;
  logic          prog_we;
  logic          prog_rdy;

  modport master (
    output ddrld_burstcnt, ddrld_addr, ddrld_rd, ddrld_be,
    input  ddr_busy, ddr_dout, ddr_dout_ready,
    output prog_addr, prog_data, prog_we,
    input  prog_rdy
  );

  modport slave (
    input  ddrld_burstcnt, ddrld_addr, ddrld_rd, ddrld_be,
    output ddr_busy, ddr_dout, ddr_dout_ready,
    input  prog_addr, prog_data, prog_we,
    output prog_rdy
  );
endinterface

// File: rtl/jtframe_mr_ddrld.sv
// Reads a ROM image from DDR in Avalon bursts and replays it as a little-endian byte stream on prog_*.
// First byte 2 cycles after the burst's last word; ddr_busy holds the request, prog_rdy low holds the byte.
module jtframe_mr_ddrld #(
  parameter int          BURST    = 32,
  parameter logic [28:0] DDR_BASE = 29'h0,
  parameter int          AW       = 27
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] len,
  output logic          downloading,
  output logic          done,
  jtframe_mr_ddrld_if.master bus
);
  localparam int IW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int RW = AW - 2;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] RECV  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] FIN   = 3'd4;

  logic [2:0]    st;
  logic [RW-1:0] rw;
  logic [AW-1:0] rb;
  logic [7:0]    wcnt;
  logic [7:0]    rcnt;
  logic [2:0]    bsel;
  logic [63:0]   buffer [BURST];

  logic          rd;
  logic [7:0]    burstcnt;
  logic [28:0]   addr;
  logic [AW-1:0] paddr;
  logic [7:0]    pdata;
  logic          we;

  logic [RW-1:0] words;
  logic [2:0]    nbsel;
  logic [7:0]    nrcnt;
  logic [63:0]   nword;
  logic          last_in_burst;

  assign words = RW'(len[AW-1:3]) + RW'(|len[2:0]);

  // Index of the byte that follows the one currently presented on prog_data
  assign nbsel         = bsel + 3'd1;
  assign nrcnt         = (bsel == 3'd7) ? rcnt + 8'd1 : rcnt;
  assign nword         = buffer[nrcnt[IW-1:0]];
  assign last_in_burst = (bsel == 3'd7) && (rcnt == burstcnt - 8'd1);

  function automatic logic [7:0] burst_of(input logic [RW-1:0] n);
    if (n >= RW'(BURST)) return 8'(BURST);
    return 8'(n);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst && st == RECV && bus.ddr_dout_ready)
      buffer[wcnt[IW-1:0]] <= bus.ddr_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= IDLE;
      downloading <= 1'b0;
      done        <= 1'b0;
      rd          <= 1'b0;
      burstcnt    <= 8'd0;
      addr        <= 29'd0;
      paddr       <= '0;
      pdata       <= 8'd0;
      we          <= 1'b0;
      rw          <= '0;
      rb          <= '0;
      wcnt        <= 8'd0;
      rcnt        <= 8'd0;
      bsel        <= 3'd0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: begin
          if (start) begin
            paddr <= '0;
            rb    <= len;
            rw    <= words;
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              downloading <= 1'b1;
              addr        <= DDR_BASE;
              rd          <= 1'b1;
              burstcnt    <= burst_of(words);
              st          <= REQ;
            end
          end
        end
        REQ: begin
          if (!bus.ddr_busy) begin
            rd   <= 1'b0;
            wcnt <= 8'd0;
            st   <= RECV;
          end
        end
        RECV: begin
          if (bus.ddr_dout_ready) begin
            wcnt <= wcnt + 8'd1;
            if (wcnt + 8'd1 == burstcnt) begin
              st   <= DRAIN;
              rw   <= rw - RW'(burstcnt);
              addr <= addr + 29'(burstcnt);
              rcnt <= 8'd0;
              bsel <= 3'd0;
            end
          end
        end
        DRAIN: begin
          // One idle cycle on entry lets the last written word settle before it is read
          if (!we) begin
            pdata <= buffer[0][7:0];
            we    <= 1'b1;
          end else if (bus.prog_rdy) begin
            paddr <= paddr + AW'(1);
            rb    <= rb - AW'(1);
            bsel  <= nbsel;
            rcnt  <= nrcnt;
            pdata <= nword[{nbsel, 3'b000} +: 8];
            if (rb == AW'(1) || last_in_burst) begin
              we <= 1'b0;
              if (rw != '0) begin
                rd       <= 1'b1;
                burstcnt <= burst_of(rw);
                st       <= REQ;
              end else begin
                downloading <= 1'b0;
                done        <= 1'b1;
                st          <= FIN;
              end
            end
          end
        end
        FIN:     st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.ddrld_rd       = rd;
  assign bus.ddrld_burstcnt = burstcnt;
  assign bus.ddrld_addr     = addr;
  assign bus.ddrld_be       = 8'hFF;
  assign bus.prog_addr      = paddr;
  assign bus.prog_data      = pdata;
  assign bus.prog_we        = we;
endmodule
